// File: rtl/mem_pipe_if.sv
// Request/response bundle for mem_pipe: ready/valid request channel carrying
// op/addr/data/byte-enables, and a ready/valid read-response channel.
interface mem_pipe_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) ();
    logic                      req_vld;
    logic                      req_rdy;
    logic [1:0]                req_op;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_data;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [DATA_WIDTH-1:0]     rsp_data;
    logic                      err;

    modport master (
        output req_vld, req_op, req_addr, req_data, req_be, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data, err
    );

    modport slave (
        input  req_vld, req_op, req_addr, req_data, req_be, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data, err
    );
endinterface

// File: rtl/mem_pipe.sv
// Backing-store memory with byte-enable writes, fixed read latency and an
// in-order response FIFO; outstanding reads are capped so nothing ever stalls.
module mem_pipe #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input logic       clk,
    input logic       rst,
    mem_pipe_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NBE   = DATA_WIDTH / 8;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] MAX_OUT  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LATENCY-1:0]    r_pv;
    logic [DATA_WIDTH-1:0] r_pd [LATENCY];
    logic [DATA_WIDTH-1:0] r_fd [RSP_DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_fcnt;
    logic [CW-1:0]         r_out;
    logic                  r_live;
    logic                  r_err;

    logic w_rdy;
    logic w_acc;
    logic w_rd;
    logic w_wr;
    logic w_rsvd;
    logic w_push;
    logic w_pop;
    logic w_vld;

    // r_live keeps req_rdy low until the first edge after reset release
    assign w_rdy  = r_live && (r_out < MAX_OUT);
    assign w_acc  = bus.req_vld && w_rdy && (bus.req_op != 2'd0);
    assign w_rd   = w_acc && (bus.req_op == 2'd1);
    assign w_wr   = w_acc && (bus.req_op == 2'd2);
    assign w_rsvd = w_acc && (bus.req_op == 2'd3);
    assign w_vld  = (r_fcnt != '0);
    assign w_push = r_pv[LATENCY-1];
    assign w_pop  = w_vld && bus.rsp_rdy;

    assign bus.req_rdy  = w_rdy;
    assign bus.rsp_vld  = w_vld;
    assign bus.rsp_data = r_fd[r_rp];
    assign bus.err      = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < NBE; b++) begin
                if (bus.req_be[b]) r_mem[bus.req_addr][8*b +: 8] <= bus.req_data[8*b +: 8];
            end
        end
    end

    // Read data is sampled from the array in the acceptance cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            for (int s = 0; s < LATENCY; s++) r_pd[s] <= '0;
        end else begin
            r_pv[0] <= w_rd;
            r_pd[0] <= r_mem[bus.req_addr];
            for (int s = 1; s < LATENCY; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pd[s] <= r_pd[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) r_fd[i] <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_fd[r_wp] <= r_pd[LATENCY-1];
                r_wp       <= (r_wp == LAST_PTR) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) r_rp <= (r_rp == LAST_PTR) ? '0 : r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Outstanding covers pipeline plus FIFO, so the FIFO can never overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_live <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_err  <= w_rsvd;
            case ({w_rd, w_pop})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: reference memory model plus an expected-response
// queue popped by a response monitor.
module tb_mem_pipe;
    logic clk;
    logic rst;

    mem_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8))  b8 ();
    mem_pipe_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) b16 ();

    mem_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LATENCY(2), .RSP_DEPTH(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    mem_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LATENCY(2), .RSP_DEPTH(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m8 [16];
    logic [7:0] q8 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string op_name(input logic [1:0] op);
        case (op)
            2'd1:    return "READ";
            2'd2:    return "WRITE";
            2'd3:    return "RSVD";
            default: return "INVALID";
        endcase
    endfunction

    // Drives one request, waits (bounded) for ready, returns #1 after acceptance
    task automatic do_req(input logic [1:0] op, input logic [3:0] addr,
                          input logic [7:0] data, input logic be);
        int waited = 0;
        b8.req_vld  = 1'b1;
        b8.req_op   = op;
        b8.req_addr = addr;
        b8.req_data = data;
        b8.req_be   = be;
        while (!b8.req_rdy && waited < 50) begin
            tick();
            waited++;
        end
        if (!b8.req_rdy) chk("req_rdy_timeout", {31'd0, b8.req_rdy}, 32'd1);
        if (op == 2'd2 && be) m8[addr] = data;
        if (op == 2'd1) q8.push_back(m8[addr]);
        $display("op %s addr %0h data %0h be %0b", op_name(op), addr, data, be);
        @(posedge clk);
        #1;
        b8.req_vld = 1'b0;
        b8.req_op  = 2'd0;
    endtask

    task automatic drain();
        int waited = 0;
        b8.rsp_rdy = 1'b1;
        while (q8.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        tick();
        chk("drain_empty", q8.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst && b8.rsp_vld && b8.rsp_rdy) begin
            if (q8.size() == 0) begin
                chk("unexpected_rsp", {31'd0, b8.rsp_vld}, 32'd0);
            end else begin
                chk("rsp_data", {24'd0, b8.rsp_data}, {24'd0, q8.pop_front()});
            end
        end
    end

    initial begin
        int stale;
        int waited;
        for (int i = 0; i < 16; i++) m8[i] = 8'h00;
        rst = 1'b0;
        b8.req_vld = 1'b0;  b8.req_op = 2'd0;  b8.req_addr = '0;
        b8.req_data = '0;   b8.req_be = '0;    b8.rsp_rdy = 1'b1;
        b16.req_vld = 1'b0; b16.req_op = 2'd0; b16.req_addr = '0;
        b16.req_data = '0;  b16.req_be = '0;   b16.rsp_rdy = 1'b1;

        #2;
        chk("rst_req_rdy", {31'd0, b8.req_rdy}, 32'd0);
        chk("rst_rsp_vld", {31'd0, b8.rsp_vld}, 32'd0);
        chk("rst_rsp_data", {24'd0, b8.rsp_data}, 32'd0);
        chk("rst_err", {31'd0, b8.err}, 32'd0);
        tick();
        tick();
        chk("rst_req_rdy_held", {31'd0, b8.req_rdy}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rdy_before_edge", {31'd0, b8.req_rdy}, 32'd0);
        tick();
        chk("rdy_after_release", {31'd0, b8.req_rdy}, 32'd1);

        // Read of cleared memory, with exact latency
        do_req(2'd1, 4'h3, 8'h00, 1'b0);
        chk("lat_t0", {31'd0, b8.rsp_vld}, 32'd0);
        tick();
        chk("lat_t1", {31'd0, b8.rsp_vld}, 32'd0);
        tick();
        chk("lat_t2", {31'd0, b8.rsp_vld}, 32'd1);
        chk("lat_t2_data", {24'd0, b8.rsp_data}, 32'd0);
        tick();

        // Write then read-after-write in the following cycle
        do_req(2'd2, 4'h5, 8'hA5, 1'b1);
        do_req(2'd1, 4'h5, 8'h00, 1'b0);
        tick();
        chk("raw_lat_t1", {31'd0, b8.rsp_vld}, 32'd0);
        tick();
        chk("raw_lat_t2", {31'd0, b8.rsp_vld}, 32'd1);
        chk("raw_data", {24'd0, b8.rsp_data}, 32'h0000_00A5);
        do_req(2'd2, 4'h5, 8'hFF, 1'b0);
        do_req(2'd1, 4'h5, 8'h00, 1'b0);
        drain();

        // 16-bit partial byte-enable merge
        chk("rdy16", {31'd0, b16.req_rdy}, 32'd1);
        b16.req_vld = 1'b1; b16.req_op = 2'd2; b16.req_addr = 4'h2;
        b16.req_data = 16'h1234; b16.req_be = 2'b11;
        tick();
        b16.req_data = 16'hFFFF; b16.req_be = 2'b01;
        tick();
        b16.req_op = 2'd1;
        tick();
        b16.req_vld = 1'b0; b16.req_op = 2'd0;
        waited = 0;
        while (!b16.rsp_vld && waited < 10) begin
            tick();
            waited++;
        end
        chk("be16_vld", {31'd0, b16.rsp_vld}, 32'd1);
        chk("be16_data", {16'd0, b16.rsp_data}, 32'h0000_12FF);
        tick();

        // Preload 0x10..0x14
        for (int i = 0; i < 5; i++) do_req(2'd2, 4'(i), 8'(16 + i), 1'b1);

        // Simultaneous accept and pop at outstanding = RSP_DEPTH-1
        b8.rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) do_req(2'd1, 4'(i), 8'h00, 1'b0);
        tick(); tick(); tick();
        chk("sim_rdy_pre", {31'd0, b8.req_rdy}, 32'd1);
        b8.rsp_rdy = 1'b1;
        do_req(2'd1, 4'h3, 8'h00, 1'b0);
        b8.rsp_rdy = 1'b0;
        chk("sim_rdy_post", {31'd0, b8.req_rdy}, 32'd1);
        do_req(2'd1, 4'h4, 8'h00, 1'b0);
        chk("sim_full", {31'd0, b8.req_rdy}, 32'd0);
        drain();

        // Backpressure: five reads with rsp_rdy low
        b8.rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_req(2'd1, 4'(i), 8'h00, 1'b0);
        chk("bp_rdy_drop", {31'd0, b8.req_rdy}, 32'd0);
        b8.req_vld = 1'b1; b8.req_op = 2'd1; b8.req_addr = 4'h4;
        tick(); tick(); tick();
        chk("bp_hold_vld", {31'd0, b8.rsp_vld}, 32'd1);
        chk("bp_hold_data", {24'd0, b8.rsp_data}, 32'h0000_0010);
        chk("bp_hold_rdy", {31'd0, b8.req_rdy}, 32'd0);
        tick();
        chk("bp_stable_data", {24'd0, b8.rsp_data}, 32'h0000_0010);
        b8.rsp_rdy = 1'b1;
        #1;
        chk("bp_rdy_before_pop", {31'd0, b8.req_rdy}, 32'd0);
        tick();
        chk("bp_rdy_after_pop", {31'd0, b8.req_rdy}, 32'd1);
        q8.push_back(m8[4]);
        $display("op %s addr %0h data %0h be %0b", op_name(2'd1), 4'h4, 8'h00, 1'b0);
        tick();
        b8.req_vld = 1'b0; b8.req_op = 2'd0;
        drain();

        // Reset with three reads in flight
        for (int i = 0; i < 3; i++) do_req(2'd1, 4'(i), 8'h00, 1'b0);
        chk("mid_vld_pre", {31'd0, b8.rsp_vld}, 32'd1);
        rst = 1'b0;
        q8.delete();
        for (int i = 0; i < 16; i++) m8[i] = 8'h00;
        #1;
        chk("mid_vld_rst", {31'd0, b8.rsp_vld}, 32'd0);
        chk("mid_rdy_rst", {31'd0, b8.req_rdy}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b8.rsp_vld) stale++;
        end
        chk("no_stale", stale, 32'd0);
        do_req(2'd1, 4'h0, 8'h00, 1'b0);
        drain();

        // Reserved op: one-cycle err, memory untouched
        do_req(2'd2, 4'h7, 8'h3C, 1'b1);
        chk("err_idle", {31'd0, b8.err}, 32'd0);
        do_req(2'd3, 4'h7, 8'hFF, 1'b1);
        chk("err_pulse", {31'd0, b8.err}, 32'd1);
        tick();
        chk("err_clear", {31'd0, b8.err}, 32'd0);
        do_req(2'd1, 4'h7, 8'h00, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_pipe.md
Name: mem_pipe

Overview:
- Parametrised memory model, successor to the single-cycle cache-backing memory.
- Adds ready/valid handshake on both the request and response channels, byte-enable writes, and a configurable read latency.
- Adds credit-based backpressure through an in-order response FIFO.
- Sits behind the cache as its backing store, so that cache miss/refill paths can be exercised under realistic latency and stall conditions.

Parameters:
- ADDR_WIDTH, 4: word address width; depth = 1<<ADDR_WIDTH words.
- DATA_WIDTH, 8: word width; must be a multiple of 8.
- LATENCY, 2: cycles from read acceptance to earliest rsp_vld; legal range 1..8.
- RSP_DEPTH, 4: maximum outstanding reads (pipeline plus FIFO); legal range ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  2  operation: 0 INVALID, 1 READ, 2 WRITE, 3 reserved.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  write byte enables; bit i covers data[8i+7:8i].
- rsp_vld  out  1  read response valid.
- rsp_rdy  in  1  read response ready.
- rsp_data  out  DATA_WIDTH  read data.
- err  out  1  one-cycle pulse on acceptance of a reserved op.

Behaviour:
- Reset (rst=0), applied immediately and asynchronously:
  - all memory words cleared to 0; pipeline and FIFO emptied; outstanding count = 0.
  - rsp_vld=0, rsp_data=0, err=0, req_rdy=0.
  - req_rdy rises at the first clk edge after rst returns to 1.
  - In-flight reads are discarded and never produce a response.
- Acceptance: a request is accepted in a cycle where req_vld & req_rdy & (req_op != INVALID). req_vld with op INVALID is ignored and consumes nothing.
- req_rdy = (outstanding < RSP_DEPTH). This is combinational from registered state only; it has no dependence on req_vld.
- WRITE:
  - On acceptance, each byte lane with req_be[i]=1 is updated; lanes with be=0 are unchanged.
  - be = 0 is a legal no-op write.
  - The write is visible to a READ accepted in the next cycle.
  - Writes do not change outstanding.
- READ:
  - The array is sampled in the acceptance cycle.
  - Data travels through a LATENCY-stage valid/data shift pipeline, then enters the response FIFO.
  - A read accepted at edge t is presented with rsp_vld=1 no earlier than edge t+LATENCY. It is exactly t+LATENCY if the FIFO is empty or draining.
  - Responses are returned strictly in acceptance order.
- Response channel:
  - rsp_vld/rsp_data come from the FIFO head; rsp_data holds its value while rsp_vld=1 and rsp_rdy=0.
  - A pop occurs when rsp_vld & rsp_rdy.
  - When the FIFO is empty, a pipeline output is forwarded directly. The LATENCY contract is the only guarantee: bypass and FIFO paths must be indistinguishable.
- Outstanding counter:
  - +1 on READ acceptance, -1 on pop; unchanged when both occur in the same cycle.
  - Never exceeds RSP_DEPTH, so the FIFO never overflows and the pipeline never stalls.
  - Pipeline plus FIFO storage must hold RSP_DEPTH entries.
- Reserved op (3): accepted as a no-op; err=1 for exactly one cycle.
- Address: wraps naturally within ADDR_WIDTH; out-of-range cannot occur.
- Simulation-only: one $display per accepted op reporting op name, address, data and byte enables.

Test Plan:
- Reset then READ addr 0x3 at cycle 0 → rsp_vld=1, rsp_data=0x00 at cycle 2; req_rdy=0 during reset, 1 after.
- WRITE addr 0x5 data 0xA5 be=1, then READ 0x5 in the next cycle → rsp_data=0xA5 exactly LATENCY cycles after the read.
- DATA_WIDTH=16: write 0x1234 be=2'b11, then 0xFFFF be=2'b01, then READ → rsp_data=0x12FF.
- rsp_rdy=0, issue 5 back-to-back READs of addrs 0..4 (preloaded 0x10..0x14):
  - req_rdy drops after the 4th acceptance; the 5th read is held.
  - rsp_data stays stable at 0x10.
  - Raise rsp_rdy → responses 0x10..0x14 in order, with the 5th read accepted in the cycle after the first pop.
- Simultaneous READ acceptance and pop with outstanding=RSP_DEPTH-1 → counter unchanged, req_rdy stays 1.
- Three READs in flight, assert rst=0 mid-pipeline → rsp_vld=0 immediately, and no stale responses appear after release. Separately, op=3 → err pulses for 1 cycle and memory is unchanged.
